mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Load/store unit directly upstream of the 64x16 data memory.
- Accepts load/store requests from the execute stage over a valid/ready handshake and range-checks the ALU-computed address.
- Drives the memory's write-enable, address and write-data lines for exactly one access cycle, then captures read data.
- Presents a registered response to the writeback stage, with its own valid/ready handshake and saturating event counters.

Parameters:
- DATA_W, 16, data word width; matches the memory word.
- MEM_AW, 6, memory address width (64 words).
- REQ_AW, 16, request address width (ALU result).
- RD_W, 3, destination-register tag width.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  unit can accept a request.
- req_wr  in  1  1=store, 0=load.
- req_addr  in  REQ_AW  word address from ALU.
- req_wdata  in  DATA_W  store data.
- req_rd  in  RD_W  destination register tag (loads).
- resp_valid  out  1  response available.
- resp_ready  in  1  writeback consumes the response.
- resp_data  out  DATA_W  load data; 0 for stores and errors.
- resp_rd  out  RD_W  echoed tag.
- resp_is_load  out  1  response belongs to a load.
- resp_err  out  1  address out of range; no memory access made.
- mem_wr  out  1  to memory write-enable.
- mem_addr  out  MEM_AW  to memory address.
- mem_wdata  out  DATA_W  to memory write data.
- mem_rdata  in  DATA_W  from memory read data (combinational read).
- load_cnt, store_cnt, err_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_rd=0, resp_is_load=0, resp_err=0, mem_wr=0, mem_addr=0, mem_wdata=0, all counters=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge, latch wr, addr, wdata and rd.
  - If req_addr[REQ_AW-1:MEM_AW]!=0, go to RESP with resp_err=1, resp_data=0, mem_wr held 0, and err_cnt incremented.
  - Otherwise go to ACCESS, with mem_addr=req_addr[MEM_AW-1:0], mem_wdata=req_wdata and mem_wr=req_wr, all registered.
- ACCESS:
  - Lasts exactly one cycle, with req_ready=0 and mem_wr=1 only for stores.
  - Load: resp_data is set from mem_rdata at the closing edge and load_cnt is incremented.
  - Store: resp_data=0 and store_cnt is incremented.
  - At the closing edge mem_wr clears to 0, then go to RESP.
- RESP:
  - resp_valid=1; resp_* fields stay stable until resp_ready.
  - On resp_ready, go to IDLE and clear resp_valid.
  - req_ready=0 throughout RESP; there is no same-cycle turnaround.
- Latency:
  - Request accepted at edge N; ACCESS in cycle N+1; resp_valid high from cycle N+2.
  - Minimum 3 cycles per request.
  - Error requests skip ACCESS, so resp_valid is high from cycle N+1.
- mem_wr is never high outside ACCESS.
- mem_addr and mem_wdata hold their last values in IDLE and RESP. No spurious writes are allowed, because the memory writes on level.
- Back-pressure: resp_ready=0 holds RESP indefinitely. No new request is accepted and no memory activity occurs.
- Counters saturate at 2^CNT_W-1 and do not wrap. Each counter increments exactly once per request.
- Address 63 (0x003F) is valid; address 64 (0x0040) is an error.
- req_valid while req_ready=0 is ignored; the upstream stage holds it.
- rst during ACCESS:
  - A store still commits in that cycle, since the memory is level-sensitive.
  - At the edge the FSM returns to IDLE with all outputs at reset values.
  - No response is issued and counters clear.
- rst during RESP drops the pending response.
- rst has priority over every other event at the same edge.

Decomposition:
- Package lsu_pkg holds:
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - constants DATA_W, MEM_AW, REQ_AW, RD_W, CNT_W;
  - the out-of-range check as a function.
- One sub-module, sat_counter (width CNT_W, inc, rst → count), is instantiated three times.

Test Plan:
- Store then load:
  - Store 0xBEEF to addr 5, then load addr 5 with rd=3.
  - mem_wr high exactly one cycle in ACCESS with mem_addr=5.
  - Load response at N+2 has resp_data=0xBEEF, resp_rd=3, resp_is_load=1; store_cnt=1, load_cnt=1.
- Boundary addresses:
  - Load addr 63 → normal access.
  - Load addr 64 → resp_err=1 at N+1, resp_data=0, mem_wr never high, err_cnt=1.
- Back-pressure:
  - Hold resp_ready=0 for 10 cycles after a load of 0x1234.
  - resp_valid and resp_data stay stable, req_ready=0, no mem_wr.
  - After resp_ready=1, the next request is accepted one cycle later.
- Reset mid-access:
  - Assert rst in the ACCESS cycle of a store of 0x00AA to addr 7.
  - No resp_valid; all outputs at reset values; a later load of addr 7 returns 0x00AA.
- Counter saturation:
  - Use CNT_W=2 and issue 5 loads.
  - load_cnt reads 3 after the 3rd load and stays 3; store_cnt=0 and err_cnt=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, widths and helpers for the memory-stage load/store unit.
package lsu_pkg;

  localparam int DATA_W = 16;
  localparam int MEM_AW = 6;
  localparam int REQ_AW = 16;
  localparam int RD_W   = 3;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Any set bit above the memory index field means the word is not backed by the 64-entry memory.
  function automatic logic addr_out_of_range(input logic [REQ_AW-1:0] addr);
    return addr[REQ_AW-1:MEM_AW] != '0;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b1}}) ? v : v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Count register: clears on reset, advances by one per event until full.
  always_ff @(posedge clk) begin
    if (rst)      count <= '0;
    else if (inc) count <= sat_inc(count);
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Load/store unit sitting between execute and the level-write 64x16 data memory.
// One request in flight at a time: IDLE -> ACCESS (one cycle) -> RESP, errors skip ACCESS.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_W = lsu_pkg::DATA_W,
  parameter int MEM_AW = lsu_pkg::MEM_AW,
  parameter int REQ_AW = lsu_pkg::REQ_AW,
  parameter int RD_W   = lsu_pkg::RD_W,
  parameter int CNT_W  = lsu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [REQ_AW-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [RD_W-1:0]   resp_rd,
  output logic              resp_is_load,
  output logic              resp_err,
  output logic              mem_wr,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  load_cnt,
  output logic [CNT_W-1:0]  store_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  state_e state, state_nxt;
  logic   oob;
  logic   load_inc, store_inc, err_inc;

  // State register; reset always wins and abandons any access or pending response.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, handshake outputs and counter events.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    load_inc   = 1'b0;
    store_inc  = 1'b0;
    err_inc    = 1'b0;
    oob        = addr_out_of_range(req_addr);
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (oob) begin
            state_nxt = RESP;
            err_inc   = 1'b1;
          end else begin
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        state_nxt = RESP;
        // mem_wr is high in ACCESS exactly when the request is a store.
        if (mem_wr) store_inc = 1'b1;
        else        load_inc  = 1'b1;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory drive and response registers; the memory lines only move on acceptance so
  // nothing toggles mem_wr outside the single ACCESS cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      resp_data    <= '0;
      resp_rd      <= '0;
      resp_is_load <= 1'b0;
      resp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            resp_rd      <= req_rd;
            resp_is_load <= ~req_wr;
            resp_data    <= '0;
            if (oob) begin
              resp_err <= 1'b1;
            end else begin
              resp_err  <= 1'b0;
              mem_addr  <= req_addr[MEM_AW-1:0];
              mem_wdata <= req_wdata;
              mem_wr    <= req_wr;
            end
          end
        end
        ACCESS: begin
          mem_wr    <= 1'b0;
          resp_data <= mem_wr ? '0 : mem_rdata;
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_load_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (load_inc),
    .count (load_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_store_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (store_inc),
    .count (store_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (err_cnt)
  );

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a behavioural 64x16 level-write memory.
module tb_mem_stage_lsu;

  localparam int CNT_W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [15:0] req_addr, req_wdata;
  logic [2:0]  req_rd;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_data;
  logic [2:0]  resp_rd;
  logic        resp_is_load, resp_err;
  logic        mem_wr;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [CNT_W-1:0] load_cnt, store_cnt, err_cnt;

  logic [15:0] mem [64];
  int checks = 0;
  int failures = 0;
  int wr_cycles = 0;
  int w0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_rd      (resp_rd),
    .resp_is_load (resp_is_load),
    .resp_err     (resp_err),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .load_cnt     (load_cnt),
    .store_cnt    (store_cnt),
    .err_cnt      (err_cnt)
  );

  // Memory: combinational read, write while mem_wr is high at the clock edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr === 1'b1) mem[mem_addr] <= mem_wdata;

  // Number of cycles during which the write enable was observed high.
  always @(negedge clk) if (mem_wr === 1'b1) wr_cycles++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [2:0] rd);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    req_rd = '0; resp_ready = 1'b1;
    tick(); tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cnts", {load_cnt, store_cnt, err_cnt}, 0);
    rst = 1'b0;

    // Store 0xBEEF to 5
    w0 = wr_cycles;
    issue(1'b1, 16'd5, 16'hBEEF, 3'd0);
    check("st_acc_mem_wr", mem_wr, 1);
    check("st_acc_mem_addr", mem_addr, 5);
    check("st_acc_mem_wdata", mem_wdata, 16'hBEEF);
    check("st_acc_req_ready", req_ready, 0);
    check("st_acc_resp_valid", resp_valid, 0);
    tick();
    check("st_resp_valid", resp_valid, 1);
    check("st_resp_mem_wr", mem_wr, 0);
    check("st_resp_is_load", resp_is_load, 0);
    check("st_resp_data", resp_data, 0);
    check("st_resp_err", resp_err, 0);
    check("st_store_cnt", store_cnt, 1);
    check("st_wr_cycles", wr_cycles - w0, 1);
    tick();
    check("st_idle_resp_valid", resp_valid, 0);
    check("st_idle_req_ready", req_ready, 1);

    // Load 5 into rd 3
    issue(1'b0, 16'd5, 16'h0000, 3'd3);
    check("ld_acc_mem_wr", mem_wr, 0);
    check("ld_acc_mem_addr", mem_addr, 5);
    tick();
    check("ld_resp_valid", resp_valid, 1);
    check("ld_resp_data", resp_data, 16'hBEEF);
    check("ld_resp_rd", resp_rd, 3);
    check("ld_resp_is_load", resp_is_load, 1);
    check("ld_load_cnt", load_cnt, 1);
    check("ld_store_cnt", store_cnt, 1);
    tick();

    // Highest valid address
    issue(1'b1, 16'h003F, 16'h6363, 3'd0);
    tick(); tick();
    issue(1'b0, 16'h003F, 16'h0000, 3'd1);
    check("a63_mem_addr", mem_addr, 63);
    tick();
    check("a63_resp_data", resp_data, 16'h6363);
    check("a63_resp_err", resp_err, 0);
    tick();

    // First invalid address: response one cycle after acceptance
    w0 = wr_cycles;
    issue(1'b0, 16'h0040, 16'h0000, 3'd2);
    check("a64_resp_valid", resp_valid, 1);
    check("a64_resp_err", resp_err, 1);
    check("a64_resp_data", resp_data, 0);
    check("a64_resp_rd", resp_rd, 2);
    check("a64_err_cnt", err_cnt, 1);
    check("a64_mem_wr", mem_wr, 0);
    tick();
    check("a64_no_write", wr_cycles - w0, 0);

    // Back-pressure with a competing store held on the request side
    issue(1'b1, 16'd9, 16'h1234, 3'd0);
    tick(); tick();
    resp_ready = 1'b0;
    issue(1'b0, 16'd9, 16'h0000, 3'd4);
    tick();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'd10; req_wdata = 16'h5555; req_rd = 3'd0;
    w0 = wr_cycles;
    for (int i = 0; i < 10; i++) begin
      check("bp_resp_valid", resp_valid, 1);
      check("bp_resp_data", resp_data, 16'h1234);
      check("bp_req_ready", req_ready, 0);
      check("bp_mem_wr", mem_wr, 0);
      tick();
    end
    check("bp_no_write", wr_cycles - w0, 0);
    resp_ready = 1'b1;
    tick();
    check("bp_rel_resp_valid", resp_valid, 0);
    check("bp_rel_req_ready", req_ready, 1);
    tick();
    check("bp_next_mem_wr", mem_wr, 1);
    check("bp_next_mem_addr", mem_addr, 10);
    check("bp_next_mem_wdata", mem_wdata, 16'h5555);
    req_valid = 1'b0;
    tick(); tick();
    check("bp_load_cnt_sat", load_cnt, 3);
    check("bp_store_cnt_sat", store_cnt, 3);
    check("bp_err_cnt", err_cnt, 1);

    // Reset during the ACCESS cycle of a store
    issue(1'b1, 16'd7, 16'h00AA, 3'd6);
    check("ra_mem_wr", mem_wr, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ra_resp_valid", resp_valid, 0);
    check("ra_req_ready", req_ready, 1);
    check("ra_mem_wr_clr", mem_wr, 0);
    check("ra_mem_addr", mem_addr, 0);
    check("ra_mem_wdata", mem_wdata, 0);
    check("ra_resp_fields", {resp_data, resp_rd, resp_is_load, resp_err}, 0);
    check("ra_cnts", {load_cnt, store_cnt, err_cnt}, 0);
    tick();
    check("ra_no_resp", resp_valid, 0);
    issue(1'b0, 16'd7, 16'h0000, 3'd5);
    tick();
    check("ra_ld_data", resp_data, 16'h00AA);
    check("ra_ld_cnt", load_cnt, 1);
    check("ra_st_cnt", store_cnt, 0);
    tick();

    // Reset while a response is pending
    resp_ready = 1'b0;
    issue(1'b0, 16'd7, 16'h0000, 3'd1);
    tick();
    check("rr_resp_valid", resp_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    resp_ready = 1'b1;
    check("rr_dropped", resp_valid, 0);
    check("rr_req_ready", req_ready, 1);
    check("rr_load_cnt", load_cnt, 0);

    // Saturation on 2-bit counters
    for (int i = 1; i <= 5; i++) begin
      issue(1'b0, 16'd7, 16'h0000, 3'd2);
      tick();
      check("sat_load_cnt", load_cnt, (i < 3) ? i : 3);
      tick();
    end
    check("sat_store_cnt", store_cnt, 0);
    check("sat_err_cnt", err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
